// File: rtl/p_mem_pkg.sv
// Shared types and helpers for the MEM-stage data memory responder.
// Holds the FSM state encoding, word geometry and address checking.
package p_mem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Misaligned, or any address bit above the implemented word range.
  function automatic logic addr_err(
    input logic [31:0] a,
    input int unsigned aw
  );
    return (a[1:0] != 2'b00) ||
           ((a >> (aw + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/p_dmem_array.sv
// Single-port word RAM with per-byte write enables.
// Read data is registered on every enabled edge (old contents on write).
module p_dmem_array
  import p_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [WORD_BYTES-1:0] we,
  input  logic [ADDR_W-1:0]     idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/p_dmem_responder.sv
// MEM-stage data memory responder: req/ready accept, wait states,
// one-cycle rvalid response, and pipeline stall generation.
module p_dmem_responder
  import p_mem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        stall
);

  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic               we_q;
  logic               err_q;
  logic [ADDR_W-1:0]  idx_q;
  logic [31:0]        wdata_q;
  logic [3:0]         be_q;

  logic               idle;
  logic               accept;
  logic               go_resp;
  logic               s_we;
  logic               s_err;
  logic [ADDR_W-1:0]  s_idx;
  logic [31:0]        s_wdata;
  logic [3:0]         s_be;
  logic [3:0]         ram_we;
  logic [31:0]        ram_rdata;

  assign idle   = (state == IDLE);
  assign accept = idle && req;

  assign go_resp =
    (accept && (WAIT_CYCLES == 0)) ||
    ((state == WAIT) && (cnt == '0));

  // With no wait states the RAM access happens on the
  // acceptance edge, so it must see the live inputs.
  assign s_we    = idle ? we : we_q;
  assign s_err   = idle ? addr_err(addr, ADDR_W) : err_q;
  assign s_idx   = idle ? addr[ADDR_W+1:2] : idx_q;
  assign s_wdata = idle ? wdata : wdata_q;
  assign s_be    = idle ? be : be_q;

  assign ram_we = (s_we && !s_err) ? s_be : 4'b0000;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            err_q   <= addr_err(addr, ADDR_W);
            idx_q   <= addr[ADDR_W+1:2];
            wdata_q <= wdata;
            be_q    <= be;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - 1'b1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  p_dmem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .en    (go_resp),
    .we    (ram_we),
    .idx   (s_idx),
    .wdata (s_wdata),
    .rdata (ram_rdata)
  );

  assign ready  = idle;
  assign rvalid = (state == RESP);
  assign err    = rvalid && err_q;
  assign stall  = accept || (state == WAIT);
  assign rdata  = (rvalid && !we_q && !err_q)
                ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_p_dmem_responder.sv
// Randomized, model-checked bench for p_dmem_responder.
// Two instances: WAIT_CYCLES=2 and WAIT_CYCLES=0.
module tb_p_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  bit          sel0;

  logic        req2, req0;
  logic        ready2, rvalid2, err2, stall2;
  logic        ready0, rvalid0, err0, stall0;
  logic [31:0] rdata2, rdata0;

  logic        o_ready, o_rvalid, o_err, o_stall;
  logic [31:0] o_rdata;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m2 [int];
  logic [31:0] m0 [int];

  always #5 clk = ~clk;

  assign req2 = req && !sel0;
  assign req0 = req && sel0;

  assign o_ready  = sel0 ? ready0  : ready2;
  assign o_rvalid = sel0 ? rvalid0 : rvalid2;
  assign o_err    = sel0 ? err0    : err2;
  assign o_stall  = sel0 ? stall0  : stall2;
  assign o_rdata  = sel0 ? rdata0  : rdata2;

  p_dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req(req2), .we(we),
    .addr(addr), .wdata(wdata), .be(be),
    .ready(ready2), .rvalid(rvalid2), .rdata(rdata2),
    .err(err2), .stall(stall2)
  );

  p_dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we),
    .addr(addr), .wdata(wdata), .be(be),
    .ready(ready0), .rvalid(rvalid0), .rdata(rdata0),
    .err(err0), .stall(stall0)
  );

  // 1024 words of 4 bytes: legal byte addresses are 0..4095, aligned.
  function automatic bit exp_err(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'd4096);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    int k = int'(a / 4);
    if (sel0) return m0.exists(k) ? m0[k] : 32'hx;
    return m2.exists(k) ? m2[k] : 32'hx;
  endfunction

  task automatic model_wr(input logic [31:0] a,
                          input logic [31:0] d,
                          input logic [3:0] b);
    logic [31:0] w = model_rd(a);
    int k = int'(a / 4);
    for (int i = 0; i < 4; i++)
      if (b[i]) w[8*i +: 8] = d[8*i +: 8];
    if (sel0) m0[k] = w;
    else      m2[k] = w;
  endtask

  task automatic access(input bit w_,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [3:0] b,
                        input bit scramble);
    int wc = sel0 ? 0 : 2;
    bit e = exp_err(a);
    logic [31:0] exp_rd;
    int lat = 0;
    int stalls = 1;
    exp_rd = (!w_ && !e) ? model_rd(a) : 32'd0;
    @(posedge clk); #1;
    req = 1'b1; we = w_; addr = a; wdata = d; be = b;
    @(negedge clk);
    vectors++;
    if (o_ready !== 1'b1 || o_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL accept a=%h ready=%b stall=%b required 1/1",
               a, o_ready, o_stall);
    end
    @(posedge clk); #1;
    req = 1'b0;
    if (scramble) begin
      addr = $urandom; wdata = $urandom;
      we = 1'($urandom); be = 4'($urandom);
    end
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (o_rvalid === 1'b1) begin
        lat = c;
        break;
      end
      if (o_stall === 1'b1) stalls++;
    end
    vectors++;
    if (lat != wc + 1) begin
      miscompares++;
      $display("FAIL latency a=%h got=%0d required=%0d (0=timeout)",
               a, lat, wc + 1);
    end
    vectors++;
    if (stalls != wc + 1) begin
      miscompares++;
      $display("FAIL stall_cycles a=%h got=%0d required=%0d",
               a, stalls, wc + 1);
    end
    if (lat != 0) begin
      vectors++;
      if (o_stall !== 1'b0 || o_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL resp_hs a=%h stall=%b ready=%b required 0/0",
                 a, o_stall, o_ready);
      end
      vectors++;
      if (o_err !== e) begin
        miscompares++;
        $display("FAIL err a=%h got=%b required=%b", a, o_err, e);
      end
      vectors++;
      if (o_rdata !== exp_rd) begin
        miscompares++;
        $display("FAIL rdata a=%h got=%h required=%h",
                 a, o_rdata, exp_rd);
      end
      @(negedge clk);
      vectors++;
      if (o_rvalid !== 1'b0 || o_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL post_resp a=%h rvalid=%b ready=%b required 0/1",
                 a, o_rvalid, o_ready);
      end
    end
    if (w_ && !e) model_wr(a, d, b);
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 1'b0; we = 1'b0;
    addr = '0; wdata = '0; be = '0; sel0 = 1'b0;
    #12;
    for (int s = 0; s < 2; s++) begin
      sel0 = bit'(s); #1;
      vectors++;
      if (o_ready !== 1'b1 || o_rvalid !== 1'b0 || o_stall !== 1'b0 ||
          o_err !== 1'b0 || o_rdata !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_state inst=%0d ready=%b rvalid=%b stall=%b err=%b rdata=%h required 1/0/0/0/0",
                 s, o_ready, o_rvalid, o_stall, o_err, o_rdata);
      end
    end
    sel0 = 1'b0;
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_basic();
    sel0 = 1'b0;
    access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    access(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic test_byte_enables();
    sel0 = 1'b0;
    access(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0);
    access(1'b1, 32'h20, 32'h000000AA, 4'b0001, 1'b0);
    access(1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
    vectors++;
    if (model_rd(32'h20) !== 32'h112233AA) begin
      miscompares++;
      $display("FAIL be_model got=%h required=112233aa",
               model_rd(32'h20));
    end
    access(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 1'b0);
    access(1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic test_errors();
    sel0 = 1'b0;
    access(1'b1, 32'h0, 32'h0BADF00D, 4'hF, 1'b0);
    access(1'b0, 32'h22, 32'h0, 4'h0, 1'b0);
    access(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 1'b0);
    access(1'b1, 32'h80000000, 32'h5555AAAA, 4'hF, 1'b0);
    access(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    sel0 = 1'b1;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; be = 4'hF;
    for (int k = 0; k < 8; k++) begin
      d = $urandom;
      addr = 32'h80 + 32'(4 * k);
      wdata = d;
      @(negedge clk);
      vectors++;
      if (o_ready !== (k % 2 == 0) ||
          o_rvalid !== (k % 2 == 1) ||
          o_stall !== (k % 2 == 0)) begin
        miscompares++;
        $display("FAIL b2b k=%0d ready=%b rvalid=%b stall=%b required %b/%b/%b",
                 k, o_ready, o_rvalid, o_stall,
                 k % 2 == 0, k % 2 == 1, k % 2 == 0);
      end
      if (k % 2 == 0) model_wr(addr, d, 4'hF);
      if (k % 2 == 1) begin
        vectors++;
        if (o_rdata !== 32'd0 || o_err !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_store_resp k=%0d rdata=%h err=%b required 0/0",
                   k, o_rdata, o_err);
        end
      end
      @(posedge clk); #1;
    end
    req = 1'b0;
    for (int k = 0; k < 4; k++)
      access(1'b0, 32'h80 + 32'(8 * k), 32'h0, 4'h0, 1'b1);
    access(1'b0, 32'h81, 32'h0, 4'h0, 1'b0);
    sel0 = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    int seen = 0;
    sel0 = 1'b0;
    access(1'b1, 32'h40, 32'h0, 4'hF, 1'b0);
    access(1'b1, 32'h44, 32'h0, 4'hF, 1'b0);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = 32'h40;
    wdata = 32'hCAFEF00D; be = 4'hF;
    @(posedge clk); #1;
    req = 1'b0;
    reset = 1'b0; #1;
    vectors++;
    if (o_ready !== 1'b1 || o_rvalid !== 1'b0 || o_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_wait ready=%b rvalid=%b stall=%b required 1/0/0",
               o_ready, o_rvalid, o_stall);
    end
    @(negedge clk); reset = 1'b1;
    access(1'b0, 32'h40, 32'h0, 4'h0, 1'b0);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = 32'h44;
    wdata = 32'h12345678; be = 4'hF;
    @(posedge clk); #1;
    req = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_rvalid === 1'b1) begin
        seen = 1;
        break;
      end
    end
    vectors++;
    if (seen == 0) begin
      miscompares++;
      $display("FAIL resp_timeout rvalid=%b required 1", o_rvalid);
    end
    reset = 1'b0; #1;
    vectors++;
    if (o_ready !== 1'b1 || o_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_resp ready=%b rvalid=%b required 1/0",
               o_ready, o_rvalid);
    end
    model_wr(32'h44, 32'h12345678, 4'hF);
    @(negedge clk); reset = 1'b1;
    access(1'b0, 32'h44, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic test_input_hold();
    sel0 = 1'b0;
    access(1'b1, 32'h60, 32'hA5A5A5A5, 4'hF, 1'b1);
    access(1'b0, 32'h60, 32'h0, 4'h0, 1'b1);
    access(1'b1, 32'h64, 32'h5A5A5A5A, 4'b1100, 1'b1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    sel0 = 1'b0;
    for (int k = 0; k < 16; k++)
      access(1'b1, 32'h100 + 32'(4 * k), $urandom, 4'hF, 1'b1);
    for (int n = 0; n < 40; n++) begin
      a = 32'h100 + 32'(4 * $urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0)
        a = ($urandom_range(0, 1) == 1) ? (a | 32'h1) : (a | 32'h2000);
      access(1'($urandom), a, $urandom, 4'($urandom), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_enables();
    test_errors();
    test_back_to_back();
    test_reset_mid_op();
    test_input_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
